// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the 8-bit ALU and its execute-stage wrapper:
//   datapath constants, the opcode encoding and an opcode legality check.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int DW  = 8;  // datapath width
  localparam int RW  = 3;  // register index width (8 architectural registers)
  localparam int OPW = 5;  // opcode width

  // Result returned for an undefined opcode.
  localparam logic [DW-1:0] ALU_ERR_VAL = 8'hFF;

  typedef enum logic [OPW-1:0] {
    OP_AND = 5'b00000,
    OP_OR  = 5'b00001,
    OP_NOT = 5'b00010,
    OP_XOR = 5'b00011,
    OP_ADD = 5'b00100,
    OP_SUB = 5'b00101,
    OP_LSL = 5'b10000,
    OP_LSR = 5'b10001
  } alu_op_e;

  // Legality comes from the encoding itself, never from the result value:
  // SUB 0-1 legitimately produces ALU_ERR_VAL.
  function automatic logic is_valid_op(input logic [OPW-1:0] op);
    case (op)
      OP_AND, OP_OR, OP_NOT, OP_XOR,
      OP_ADD, OP_SUB, OP_LSL, OP_LSR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage : alu_pkg

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   Purely combinational 8-bit unsigned ALU. Results are truncated to DW.
//
//   i_op      opcode (alu_op_e encoding)
//   i_in1     first operand
//   i_in2     second operand; also the full shift amount for LSL/LSR
//   o_result  result; ALU_ERR_VAL for an undefined opcode
// -----------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  logic [OPW-1:0] i_op,
  input  logic [DW-1:0]  i_in1,
  input  logic [DW-1:0]  i_in2,
  output logic [DW-1:0]  o_result
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives o_result
    // and no latch is inferred.
    o_result = ALU_ERR_VAL;
    case (i_op)
      OP_AND:  o_result = i_in1 & i_in2;
      OP_OR:   o_result = i_in1 | i_in2;
      OP_XOR:  o_result = i_in1 ^ i_in2;
      OP_NOT:  o_result = (i_in1 == '0) ? {{(DW-1){1'b0}}, 1'b1} : '0;
      OP_ADD:  o_result = i_in1 + i_in2;
      OP_SUB:  o_result = i_in1 - i_in2;
      // The whole of i_in2 is the shift amount, so any amount >= DW
      // shifts every bit out and yields 0.
      OP_LSL:  o_result = i_in1 << i_in2;
      OP_LSR:  o_result = i_in1 >> i_in2;
      default: o_result = ALU_ERR_VAL;
    endcase
  end

endmodule : alu

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
//   Execute-stage wrapper around the 8-bit ALU. Two registered stages:
//     S1: operands, opcode, rd, wen  (ALU evaluates S1 combinationally)
//     S2: result, zero, err, rd, wen (drives the writeback outputs)
//   valid/ready handshakes on both sides; 1 op/cycle throughput; results in
//   flight are forwarded into operands being accepted so dependent ops
//   never stall.
//
//   clk, rst_n                   clock (rising edge), async active-low reset
//   in_valid / in_ready          decode handshake (in_ready is independent
//                                of in_valid)
//   in_op                        ALU opcode
//   in_rs1_idx / in_rs2_idx      source register indices (forwarding compare)
//   in_rs1_val / in_rs2_val      register-file read data
//   in_rd_idx, in_wen            destination register and write enable
//   out_valid / out_ready        writeback handshake
//   out_rd_idx, out_wen          registered destination and write enable
//   out_result, out_zero         registered result and result==0
//   out_err                      opcode was not a defined ALU operation
// -----------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int DW  = alu_pkg::DW,   // must match the ALU
  parameter int RW  = alu_pkg::RW,
  parameter int OPW = alu_pkg::OPW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [RW-1:0]  in_rs1_idx,
  input  logic [RW-1:0]  in_rs2_idx,
  input  logic [DW-1:0]  in_rs1_val,
  input  logic [DW-1:0]  in_rs2_val,
  input  logic [RW-1:0]  in_rd_idx,
  input  logic           in_wen,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [RW-1:0]  out_rd_idx,
  output logic           out_wen,
  output logic [DW-1:0]  out_result,
  output logic           out_zero,
  output logic           out_err
);

  import alu_pkg::*;

  // S1 registers
  logic           r_s1_valid;
  logic [OPW-1:0] r_s1_op;
  logic [DW-1:0]  r_s1_a;
  logic [DW-1:0]  r_s1_b;
  logic [RW-1:0]  r_s1_rd;
  logic           r_s1_wen;

  // S2 registers
  logic           r_s2_valid;
  logic [DW-1:0]  r_s2_result;
  logic           r_s2_zero;
  logic           r_s2_err;
  logic [RW-1:0]  r_s2_rd;
  logic           r_s2_wen;

  logic           w_s2_adv;
  logic           w_s1_adv;
  logic           w_accept;
  logic [DW-1:0]  w_alu_result;
  logic [DW-1:0]  w_rs1_fwd;
  logic [DW-1:0]  w_rs2_fwd;

  // Handshake: S2 frees when empty or drained; S1 frees when it moves on.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = r_s1_valid && w_s2_adv;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && in_ready;

  alu u_alu (
    .i_op     (r_s1_op),
    .i_in1    (r_s1_a),
    .i_in2    (r_s1_b),
    .o_result (w_alu_result)
  );

  // Forwarding. S1 is youngest, so it wins over S2. An accept with S1 valid
  // implies S1 is advancing, so its ALU output is the value about to retire
  // into S2. S2 still forwards in its handoff cycle because the register
  // file commit of that value is not visible to decode until the next cycle.
  always_comb begin
    w_rs1_fwd = in_rs1_val;
    if (r_s1_valid && r_s1_wen && (r_s1_rd == in_rs1_idx)) begin
      w_rs1_fwd = w_alu_result;
    end else if (r_s2_valid && r_s2_wen && (r_s2_rd == in_rs1_idx)) begin
      w_rs1_fwd = r_s2_result;
    end

    w_rs2_fwd = in_rs2_val;
    if (r_s1_valid && r_s1_wen && (r_s1_rd == in_rs2_idx)) begin
      w_rs2_fwd = w_alu_result;
    end else if (r_s2_valid && r_s2_wen && (r_s2_rd == in_rs2_idx)) begin
      w_rs2_fwd = r_s2_result;
    end
  end

  // S1: payload loads only on accept; otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload fields are reset as well as valid so that a reset
      // leaves every observable register at a known zero.
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_rd    <= '0;
      r_s1_wen   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      r_s1_valid <= w_accept || (r_s1_valid && !w_s2_adv);
      if (w_accept) begin
        r_s1_op  <= in_op;
        r_s1_a   <= w_rs1_fwd;
        r_s1_b   <= w_rs2_fwd;
        r_s1_rd  <= in_rd_idx;
        r_s1_wen <= in_wen;
      end
    end
  end

  // S2: loads from the ALU when S1 advances; holds while stalled, which
  // keeps every out_* field stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_zero   <= 1'b0;
      r_s2_err    <= 1'b0;
      r_s2_rd     <= '0;
      r_s2_wen    <= 1'b0;
    end else begin
      r_s2_valid <= w_s1_adv || (r_s2_valid && !out_ready);
      if (w_s1_adv) begin
        r_s2_result <= w_alu_result;
        r_s2_zero   <= (w_alu_result == '0);
        r_s2_err    <= !is_valid_op(r_s1_op);
        r_s2_rd     <= r_s1_rd;
        r_s2_wen    <= r_s1_wen;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_zero   = r_s2_zero;
  assign out_err    = r_s2_err;
  assign out_rd_idx = r_s2_rd;
  assign out_wen    = r_s2_wen;

endmodule : alu_exec_stage

// File: tb/tb_alu_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_stage
//   Self-checking bench for alu_exec_stage. Expected results are pushed to a
//   scoreboard queue on accept and popped by a monitor on each writeback.
// -----------------------------------------------------------------------------
module tb_alu_exec_stage;

  import alu_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_op;
  logic [RW-1:0]  in_rs1_idx;
  logic [RW-1:0]  in_rs2_idx;
  logic [DW-1:0]  in_rs1_val;
  logic [DW-1:0]  in_rs2_val;
  logic [RW-1:0]  in_rd_idx;
  logic           in_wen;
  logic           out_valid;
  logic           out_ready;
  logic [RW-1:0]  out_rd_idx;
  logic           out_wen;
  logic [DW-1:0]  out_result;
  logic           out_zero;
  logic           out_err;

  alu_exec_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1_idx (in_rs1_idx),
    .in_rs2_idx (in_rs2_idx),
    .in_rs1_val (in_rs1_val),
    .in_rs2_val (in_rs2_val),
    .in_rd_idx  (in_rd_idx),
    .in_wen     (in_wen),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd_idx (out_rd_idx),
    .out_wen    (out_wen),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] result;
    logic       err;
    logic [2:0] rd;
    logic       wen;
  } exp_t;

  exp_t sb[$];
  int   pop_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Independent reference for the ALU.
  function automatic logic [7:0] alu_ref(input logic [4:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] t;
    t = {8'h00, a} << b[2:0];
    case (op)
      5'b00000: return a & b;
      5'b00001: return a | b;
      5'b00010: return (a == 8'h00) ? 8'h01 : 8'h00;
      5'b00011: return a ^ b;
      5'b00100: return a + b;
      5'b00101: return a - b;
      5'b10000: return (b >= 8'd8) ? 8'h00 : t[7:0];
      5'b10001: return (b >= 8'd8) ? 8'h00 : (a >> b[2:0]);
      default:  return 8'hFF;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random backpressure while enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: scoreboard compare on every handoff, plus hold check on stalls.
  initial begin
    logic        held;
    logic [14:0] snap;
    exp_t        e;
    held = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held)
          check("hold", {out_valid, out_rd_idx, out_wen, out_result, out_zero, out_err}, snap);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = sb.pop_front();
            check("result", out_result, e.result);
            check("zero", out_zero, (e.result == 8'h00));
            check("err", out_err, e.err);
            check("rd", out_rd_idx, e.rd);
            check("wen", out_wen, e.wen);
            pop_log.push_back(cyc);
          end
        end
        held = out_valid && !out_ready;
        snap = {out_valid, out_rd_idx, out_wen, out_result, out_zero, out_err};
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [2:0] rs1, input logic [7:0] v1,
                       input logic [2:0] rs2, input logic [7:0] v2, input logic [2:0] rd,
                       input logic wen, input logic [7:0] er, input logic ee);
    logic ok;
    logic done;
    exp_t e;
    done = 1'b0;
    in_valid = 1'b1; in_op = op; in_rs1_idx = rs1; in_rs1_val = v1;
    in_rs2_idx = rs2; in_rs2_val = v2; in_rd_idx = rd; in_wen = wen;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        e = '{result: er, err: ee, rd: rd, wen: wen};
        sb.push_back(e);
        acc_cyc = cyc;
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      if (sb.size() == 0 && !out_valid) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] op;
    logic [7:0] v1, v2;
    int a0;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs1_idx = '0; in_rs2_idx = '0; in_rs1_val = '0; in_rs2_val = '0;
    in_rd_idx = '0; in_wen = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_wen", out_wen, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_rd", out_rd_idx, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Basic ADD and latency.
    issue(OP_ADD, 3'd1, 8'h0F, 3'd2, 8'h01, 3'd4, 1'b1, 8'h10, 1'b0);
    @(negedge clk);
    check("lat_not_early", out_valid, 0);
    @(negedge clk);
    check("lat_out_valid", out_valid, 1);
    check("basic_result", out_result, 8'h10);
    @(posedge clk);
    #1;
    drain();

    // Dependent chain: S1 forwarding then S1+S2 forwarding.
    pop_log.delete();
    issue(OP_ADD, 3'd6, 8'd3, 3'd7, 8'd4, 3'd1, 1'b1, 8'h07, 1'b0);
    a0 = acc_cyc;
    issue(OP_SUB, 3'd1, 8'd0, 3'd6, 8'd7, 3'd2, 1'b1, 8'h00, 1'b0);
    issue(OP_XOR, 3'd1, 8'd0, 3'd2, 8'd0, 3'd3, 1'b1, 8'h07, 1'b0);
    drain();
    check("fwd_count", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      check("fwd_latency", pop_log[0], a0 + 1);
      check("fwd_consec1", pop_log[1], pop_log[0] + 1);
      check("fwd_consec2", pop_log[2], pop_log[1] + 1);
    end

    // Boundaries and illegal opcode.
    issue(OP_LSL, 3'd0, 8'h81, 3'd0, 8'd1, 3'd0, 1'b0, 8'h02, 1'b0);
    issue(OP_LSR, 3'd0, 8'hFF, 3'd0, 8'd8, 3'd0, 1'b0, 8'h00, 1'b0);
    issue(OP_SUB, 3'd0, 8'h00, 3'd0, 8'd1, 3'd0, 1'b0, 8'hFF, 1'b0);
    issue(OP_NOT, 3'd0, 8'h00, 3'd0, 8'h33, 3'd0, 1'b0, 8'h01, 1'b0);
    issue(OP_NOT, 3'd0, 8'h5A, 3'd0, 8'h33, 3'd0, 1'b0, 8'h00, 1'b0);
    issue(5'b11111, 3'd0, 8'h12, 3'd0, 8'h34, 3'd5, 1'b1, 8'hFF, 1'b1);
    drain();

    // Backpressure: two accepts fill the pipe, the third waits.
    out_ready = 1'b0;
    issue(OP_ADD, 3'd0, 8'd1, 3'd0, 8'd2, 3'd1, 1'b0, 8'd3, 1'b0);
    issue(OP_SUB, 3'd0, 8'd9, 3'd0, 8'd2, 3'd2, 1'b0, 8'd7, 1'b0);
    in_valid = 1'b1; in_op = OP_XOR; in_rs1_val = 8'd5; in_rs2_val = 8'd3;
    in_rd_idx = 3'd3; in_wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_result", out_result, 8'd3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(OP_XOR, 3'd0, 8'd5, 3'd0, 8'd3, 3'd3, 1'b0, 8'd6, 1'b0);
    drain();

    // Random independent ops with random backpressure and idle gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 8))
        0: op = OP_AND;  1: op = OP_OR;   2: op = OP_NOT;
        3: op = OP_XOR;  4: op = OP_ADD;  5: op = OP_SUB;
        6: op = OP_LSL;  7: op = OP_LSR;  default: op = 5'b01010;
      endcase
      v1 = 8'($urandom);
      v2 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        in_op = 5'($urandom); in_rs1_val = 8'($urandom); in_rd_idx = 3'($urandom);
        @(posedge clk);
        #1;
      end
      issue(op, 3'($urandom), v1, 3'($urandom), v2, 3'($urandom), 1'b0,
            alu_ref(op, v1, v2), (op == 5'b01010));
    end
    rand_ready = 1'b0;
    drain();

    // Asynchronous reset with two ops in flight.
    out_ready = 1'b0;
    issue(OP_ADD, 3'd0, 8'd1, 3'd0, 8'd1, 3'd3, 1'b1, 8'd2, 1'b0);
    issue(OP_ADD, 3'd0, 8'd5, 3'd0, 8'd6, 3'd4, 1'b1, 8'd11, 1'b0);
    #2;
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_result", out_result, 0);
    check("arst_out_wen", out_wen, 0);
    check("arst_out_rd", out_rd_idx, 0);
    check("arst_out_zero", out_zero, 0);
    check("arst_out_err", out_err, 0);
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_alu_exec_stage
